// File: rtl/approx_mult_dot_accum.sv
// Saturating dot-product accumulator for approximate-multiplier products.
// A running sum feeds a one-entry result register; each side has its own valid/ready handshake.
module approx_mult_dot_accum #(
    parameter int LEN   = 16,
    parameter int ACC_W = 24,
    localparam int CNT_W = $clog2(LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [15:0]      prod,
    input  logic             prod_last,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_data,
    output logic [CNT_W-1:0] acc_terms,
    output logic             acc_sat
);

    logic [ACC_W-1:0] sum_q, sum_d, sum_acc;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sat_q, sat_d, sat_acc;
    logic             vld_q, vld_d;
    logic [ACC_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] terms_q, terms_d;
    logic             osat_q, osat_d;
    logic [ACC_W:0]   ns;
    logic             accept, term;

    // Reset is folded in so the block never advertises ready while held in reset.
    assign prod_ready = rst_n & ~flush & (~vld_q | acc_ready);
    assign accept     = prod_valid & prod_ready;
    assign term       = accept & (prod_last | (cnt_q == CNT_W'(LEN - 1)));

    assign ns      = {1'b0, sum_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};
    assign sum_acc = ns[ACC_W] ? {ACC_W{1'b1}} : ns[ACC_W-1:0];
    assign sat_acc = sat_q | ns[ACC_W];
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        vld_d   = vld_q;
        data_d  = data_q;
        terms_d = terms_q;
        osat_d  = osat_q;
        if (flush || term) begin
            sum_d = '0;
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (accept) begin
            sum_d = sum_acc;
            cnt_d = cnt_inc;
            sat_d = sat_acc;
        end
        // A load in the same cycle as a drain wins, so no result is dropped.
        if (term) begin
            vld_d   = 1'b1;
            data_d  = sum_acc;
            terms_d = cnt_inc;
            osat_d  = sat_acc;
        end else if (vld_q && acc_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            terms_q <= '0;
            osat_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            vld_q   <= vld_d;
            data_q  <= data_d;
            terms_q <= terms_d;
            osat_q  <= osat_d;
        end
    end

    assign acc_valid = vld_q;
    assign acc_data  = data_q;
    assign acc_terms = terms_q;
    assign acc_sat   = osat_q;

endmodule

// File: tb/tb_approx_mult_dot_accum.sv
// Directed bench: A (LEN=4, ACC_W=24), B (LEN=4, ACC_W=17, saturation), C (LEN=1).
module tb_approx_mult_dot_accum;
    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic [15:0] prod = '0;
    logic        prod_last = 1'b0;
    logic        a_v = 1'b0, b_v = 1'b0, c_v = 1'b0;
    logic        a_ar = 1'b1, b_ar = 1'b1, c_ar = 1'b1;
    logic        a_pr, a_av, a_s, b_pr, b_av, b_s, c_pr, c_av, c_s;
    logic [23:0] a_d, c_d;
    logic [16:0] b_d;
    logic [2:0]  a_t, b_t;
    logic [0:0]  c_t;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    approx_mult_dot_accum #(.LEN(4), .ACC_W(24)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .prod_valid(a_v), .prod_ready(a_pr),
        .prod(prod), .prod_last(prod_last), .acc_valid(a_av), .acc_ready(a_ar),
        .acc_data(a_d), .acc_terms(a_t), .acc_sat(a_s));
    approx_mult_dot_accum #(.LEN(4), .ACC_W(17)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .prod_valid(b_v), .prod_ready(b_pr),
        .prod(prod), .prod_last(prod_last), .acc_valid(b_av), .acc_ready(b_ar),
        .acc_data(b_d), .acc_terms(b_t), .acc_sat(b_s));
    approx_mult_dot_accum #(.LEN(1), .ACC_W(24)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .prod_valid(c_v), .prod_ready(c_pr),
        .prod(prod), .prod_last(prod_last), .acc_valid(c_av), .acc_ready(c_ar),
        .acc_data(c_d), .acc_terms(c_t), .acc_sat(c_s));

    // Presents one beat to the selected DUT for one cycle; starts and ends at a negedge.
    task automatic beat(input int sel, input logic [15:0] p, input logic last);
        prod = p; prod_last = last;
        if (sel == 0) a_v = 1'b1; else if (sel == 1) b_v = 1'b1; else c_v = 1'b1;
        @(negedge clk);
        a_v = 1'b0; b_v = 1'b0; c_v = 1'b0; prod_last = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (a_pr !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", a_pr); end
        checks++; if ({a_av, a_s} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {a_av, a_s}); end
        checks++; if (a_d !== 24'd0 || a_t !== 3'd0) begin errors++; $display("FAIL reset_data: got %0d/%0d want 0/0", a_d, a_t); end
        rst_n = 1'b1; #1;
        checks++; if (a_pr !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %0b want 1", a_pr); end
        @(negedge clk);
    endtask

    task automatic test_basic_sum();
        a_ar = 1'b1;
        beat(0, 16'd100, 1'b0); beat(0, 16'd200, 1'b0); beat(0, 16'd300, 1'b0);
        checks++; if (a_av !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b want 0", a_av); end
        beat(0, 16'd400, 1'b0);
        checks++; if (a_av !== 1'b1 || a_d !== 24'd1000 || a_t !== 3'd4 || a_s !== 1'b0)
            begin errors++; $display("FAIL basic_sum: got v%0b d%0d t%0d s%0b want v1 d1000 t4 s0", a_av, a_d, a_t, a_s); end
        @(negedge clk);
    endtask

    task automatic test_early_close();
        a_ar = 1'b1;
        beat(0, 16'd7, 1'b0); beat(0, 16'd9, 1'b1);
        checks++; if (a_av !== 1'b1 || a_d !== 24'd16 || a_t !== 3'd2)
            begin errors++; $display("FAIL early_close: got v%0b d%0d t%0d want v1 d16 t2", a_av, a_d, a_t); end
        beat(0, 16'd5, 1'b1);
        checks++; if (a_av !== 1'b1 || a_d !== 24'd5 || a_t !== 3'd1)
            begin errors++; $display("FAIL early_close_next: got v%0b d%0d t%0d want v1 d5 t1", a_av, a_d, a_t); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        b_ar = 1'b1;
        for (int i = 0; i < 4; i++) beat(1, 16'd65535, 1'b0);
        checks++; if (b_av !== 1'b1 || b_d !== 17'd131071 || b_t !== 3'd4 || b_s !== 1'b1)
            begin errors++; $display("FAIL saturation: got v%0b d%0d t%0d s%0b want v1 d131071 t4 s1", b_av, b_d, b_t, b_s); end
        beat(1, 16'd1, 1'b1);
        checks++; if (b_av !== 1'b1 || b_d !== 17'd1 || b_t !== 3'd1 || b_s !== 1'b0)
            begin errors++; $display("FAIL sat_cleared: got v%0b d%0d t%0d s%0b want v1 d1 t1 s0", b_av, b_d, b_t, b_s); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        a_ar = 1'b0;
        beat(0, 16'd100, 1'b0); beat(0, 16'd200, 1'b0); beat(0, 16'd300, 1'b0); beat(0, 16'd400, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checks++; if (a_pr !== 1'b0 || a_av !== 1'b1 || a_d !== 24'd1000)
                begin errors++; $display("FAIL backpressure_hold[%0d]: got r%0b v%0b d%0d want r0 v1 d1000", i, a_pr, a_av, a_d); end
            @(negedge clk);
        end
        a_ar = 1'b1; #1;
        checks++; if (a_pr !== 1'b1) begin errors++; $display("FAIL ready_on_handshake: got %0b want 1", a_pr); end
        @(negedge clk);
        checks++; if (a_av !== 1'b0 || a_d !== 24'd1000)
            begin errors++; $display("FAIL drain: got v%0b d%0d want v0 d1000", a_av, a_d); end
    endtask

    task automatic test_flush();
        a_ar = 1'b1;
        beat(0, 16'd50, 1'b0); beat(0, 16'd60, 1'b0);
        flush = 1'b1; a_v = 1'b1; prod = 16'd999; #1;
        checks++; if (a_pr !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", a_pr); end
        @(negedge clk);
        flush = 1'b0; a_v = 1'b0;
        beat(0, 16'd70, 1'b1);
        checks++; if (a_av !== 1'b1 || a_d !== 24'd70 || a_t !== 3'd1)
            begin errors++; $display("FAIL flush_discard: got v%0b d%0d t%0d want v1 d70 t1", a_av, a_d, a_t); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int acc_cnt = 0;
        a_ar = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prod = 16'(i + 1); a_v = 1'b1; #1;
            if (a_pr) acc_cnt++;
            @(negedge clk);
            if (i == 3) begin
                checks++; if (a_av !== 1'b1 || a_d !== 24'd10 || a_t !== 3'd4)
                    begin errors++; $display("FAIL b2b_first: got v%0b d%0d t%0d want v1 d10 t4", a_av, a_d, a_t); end
            end
            if (i == 7) begin
                checks++; if (a_av !== 1'b1 || a_d !== 24'd26 || a_t !== 3'd4)
                    begin errors++; $display("FAIL b2b_second: got v%0b d%0d t%0d want v1 d26 t4", a_av, a_d, a_t); end
            end
        end
        a_v = 1'b0;
        checks++; if (acc_cnt != 8) begin errors++; $display("FAIL b2b_accepts: got %0d want 8", acc_cnt); end
        @(negedge clk);
    endtask

    task automatic test_len1();
        c_ar = 1'b1;
        beat(2, 16'd42, 1'b0);
        checks++; if (c_av !== 1'b1 || c_d !== 24'd42 || c_t !== 1'd1)
            begin errors++; $display("FAIL len1_first: got v%0b d%0d t%0d want v1 d42 t1", c_av, c_d, c_t); end
        beat(2, 16'd8, 1'b0);
        checks++; if (c_av !== 1'b1 || c_d !== 24'd8 || c_t !== 1'd1)
            begin errors++; $display("FAIL len1_second: got v%0b d%0d t%0d want v1 d8 t1", c_av, c_d, c_t); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        a_ar = 1'b1;
        beat(0, 16'd3, 1'b0);
        rst_n = 1'b0; #1;
        checks++; if (a_pr !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %0b want 0", a_pr); end
        @(negedge clk); rst_n = 1'b1;
        beat(0, 16'd5, 1'b1);
        checks++; if (a_d !== 24'd5 || a_t !== 3'd1)
            begin errors++; $display("FAIL reset_partial_lost: got d%0d t%0d want d5 t1", a_d, a_t); end
        a_ar = 1'b0;
        rst_n = 1'b0; #1;
        checks++; if (a_av !== 1'b0 || a_d !== 24'd0 || a_t !== 3'd0 || a_s !== 1'b0)
            begin errors++; $display("FAIL reset_async_outputs: got v%0b d%0d t%0d s%0b want all 0", a_av, a_d, a_t, a_s); end
        @(negedge clk); rst_n = 1'b1; a_ar = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_early_close();
        test_saturation();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_len1();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/approx_mult_dot_accum.md
# approx_mult_dot_accum

Sequential dot-product accumulator that sits directly downstream of the combinational approximate unsigned 8x8 multipliers. It accepts one 16-bit product per cycle over a valid/ready stream and sums products into a saturating accumulator. It closes a dot product on an explicit last flag or after LEN terms, then presents the sum through a one-entry output register with its own valid/ready handshake. Accumulation continues while a finished result waits in the output register, so throughput is one product per cycle when the consumer keeps up.

## Interface
- LEN, 16: maximum terms per dot product; legal range ≥ 1.
- ACC_W, 24: accumulator and result width; legal range ≥ 16.
- CNT_W, $clog2(LEN+1): width of the term counter (derived, not overridden).
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- flush  in  1  synchronous discard of the partial sum and term count.
- prod_valid  in  1  product beat valid.
- prod_ready  out  1  block accepts a beat this cycle.
- prod  in  16  unsigned product from the multiplier stage (its z output).
- prod_last  in  1  the beat is the final term of the current dot product.
- acc_valid  out  1  result register holds an unconsumed result.
- acc_ready  in  1  consumer accepts the result.
- acc_data  out  ACC_W  final saturated sum.
- acc_terms  out  CNT_W  number of terms in acc_data, 1..LEN.
- acc_sat  out  1  saturation occurred anywhere in this dot product.

## Operation
- Running state: `sum` (ACC_W bits), `cnt` (CNT_W bits), and `sat` (sticky). Output state: `acc_data`, `acc_terms`, `acc_sat`, and `acc_valid`.
- Beat accepted = prod_valid & prod_ready.
- prod_ready = !flush & (!acc_valid | acc_ready). prod_ready never depends on prod_valid or prod_last.
- On an accepted beat:
  - ns = sum + zero-extended prod, computed at ACC_W+1 bits.
  - If ns ≥ 2^ACC_W, the new sum is 2^ACC_W−1 and sat is set. Otherwise the new sum is ns.
  - cnt increments by 1.
- Terminating beat: an accepted beat with prod_last=1, or one accepted while cnt == LEN−1.
  - On the terminating beat, the output register loads the new sum, cnt+1, and the new sat value, and acc_valid goes to 1.
  - In the same edge, sum, cnt, and sat clear to 0.
- Result drain: if acc_valid & acc_ready and the output register is not loading in the same cycle, acc_valid goes to 0 and the data fields hold their values.
- Result drain and terminating-beat load in the same cycle: the load wins and acc_valid stays 1. No result is lost.
- flush=1: sum, cnt, and sat clear to 0, and no beat is accepted. The output register and its handshake are unaffected.
- prod_last on a beat that is not accepted has no effect.
- No state machine beyond the two-slot structure: a running accumulator plus one output register.

## Timing
- Reset values while rst_n=0:
  - prod_ready = 0.
  - acc_valid = 0, acc_data = 0, acc_terms = 0, acc_sat = 0.
  - Internally, sum = 0, cnt = 0, sat = 0.
- After deassertion, prod_ready = 1 in the first cycle unless flush is high.
- Latency: acc_valid rises on the edge that accepts the terminating beat. The result is visible the cycle after that beat.
- Throughput: with acc_ready held at 1, one beat is accepted every cycle, including across dot-product boundaries, with no bubbles.
- Backpressure:
  - While acc_valid=1 and acc_ready=0, prod_ready = 0.
  - Output fields stay stable while acc_valid=1 and acc_ready=0.
  - acc_valid never drops without a handshake, except on reset.
- Reset asserted mid-dot-product or with a pending result: all state is lost immediately, with no partial output.
- LEN=1: every accepted beat is terminating and acc_terms = 1.

## Test plan
- Basic sum (LEN=4, ACC_W=24): beats 100, 200, 300, 400 with no prod_last → one cycle after the 4th beat, acc_valid=1, acc_data=1000, acc_terms=4, acc_sat=0.
- Early close: beats 7, 9 with prod_last on the 2nd → acc_data=16, acc_terms=2. The next beat 5 (prod_last=1) → acc_data=5, acc_terms=1.
- Saturation (ACC_W=17, LEN=4): four beats of 65535 → acc_data=131071, acc_sat=1, acc_terms=4. The next dot product with beat 1 (prod_last=1) → acc_sat=0.
- Backpressure:
  - acc_ready=0 while the first result (1000) is pending → prod_ready=0 and acc_data holds 1000 for 10 cycles.
  - Raise acc_ready → handshake occurs and prod_ready returns to 1 in the same cycle.
  - Streaming 8 beats at LEN=4 with acc_ready=1 takes exactly 8 accepting cycles.
- Flush and reset:
  - Beats 50, 60, then flush=1 for one cycle, then 70 with prod_last=1 → acc_data=70, acc_terms=1.
  - Assert rst_n=0 mid-sum with a result pending → all outputs go to 0 asynchronously, before the next clock edge.
